interrupt_ctrl: RTL and testbench

Interrupt controller that sits directly upstream of the CPU core. It latches edge-triggered requests from peripherals and prioritises them. It raises a request to the control unit and supplies the 16-bit `interruptVector` consumed by the instruction-memory address mux (select `3'b010`). Software reaches its pending, mask and status registers through the 8-bit I/O address space on the data-memory bus (`dMemAddressSelect = 1`, address `iMemOut[11:4]`).

---
 rtl/interrupt_ctrl_if.sv | 25 ++
 rtl/interrupt_ctrl.sv | 144 ++++++++++++++
 tb/tb_interrupt_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/interrupt_ctrl_if.sv
// Signal bundle between interrupt_ctrl (slave) and the CPU/peripheral side (master).
interface interrupt_ctrl_if #(
  parameter int unsigned NUM_IRQ = 4
);
  logic [NUM_IRQ-1:0] irq_in;
  logic               global_en;
  logic               irq_req;
  logic               irq_ack;
  logic [15:0]        vector;
  logic [7:0]         io_addr;
  logic [7:0]         io_wdata;
  logic               io_wen;
  logic               io_ren;
  logic [7:0]         io_rdata;

  modport master (
    output irq_in, global_en, irq_ack, io_addr, io_wdata, io_wen, io_ren,
    input  irq_req, vector, io_rdata
  );

  modport slave (
    input  irq_in, global_en, irq_ack, io_addr, io_wdata, io_wen, io_ren,
    output irq_req, vector, io_rdata
  );
endinterface

// File: rtl/interrupt_ctrl.sv
// Interrupt controller: edge-latched requests, lowest-index priority, I/O-mapped PEND/MASK/STAT.
// Define INTCTRL_SYNC_EN to pass irq_in through a two-flop synchroniser first.
module interrupt_ctrl #(
  parameter int unsigned NUM_IRQ       = 4,
  parameter logic [15:0] VECTOR_BASE   = 16'h0004,
  parameter int unsigned VECTOR_STRIDE = 4,
  parameter logic [7:0]  IO_BASE       = 8'hF0
) (
  input  logic            clk,
  input  logic            rst,
  interrupt_ctrl_if.slave bus
);
  localparam int unsigned ID_W      = 3;
  localparam logic [7:0]  ADDR_PEND = IO_BASE;
  localparam logic [7:0]  ADDR_MASK = IO_BASE + 8'd1;
  localparam logic [7:0]  ADDR_STAT = IO_BASE + 8'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    REQ     = 2'b01,
    SERVICE = 2'b10
  } stateT;

  stateT state, stateNext;

  logic [NUM_IRQ-1:0] irqIn, irqSample, irqPrev, pend, mask;
  logic [NUM_IRQ-1:0] pendSet, pendClrSw, pendKeep, pendMasked, reqOh, pendNext;
  logic [ID_W-1:0]    winId, reqId, reqIdNext, isrId, isrIdNext;
  logic               ackTaken, wrPend, wrMask, wrStat;
  logic               irqReqQ, irqReqNext;
  logic [15:0]        vectorQ, vectorNext;
  logic [7:0]         rdataQ, rdataNext;

`ifdef INTCTRL_SYNC_EN
  logic [NUM_IRQ-1:0] syncMeta, syncOut;

  always_ff @(posedge clk) begin
    if (rst) begin
      syncMeta <= '0;
      syncOut  <= '0;
    end else begin
      syncMeta <= bus.irq_in;
      syncOut  <= syncMeta;
    end
  end

  assign irqIn = syncOut;
`else
  assign irqIn = bus.irq_in;
`endif

  assign wrPend = bus.io_wen && (bus.io_addr == ADDR_PEND);
  assign wrMask = bus.io_wen && (bus.io_addr == ADDR_MASK);
  assign wrStat = bus.io_wen && (bus.io_addr == ADDR_STAT);

  // A new edge always wins over a same-cycle software or ack clear.
  assign pendSet    = irqSample & ~irqPrev;
  assign pendClrSw  = wrPend ? NUM_IRQ'(bus.io_wdata) : '0;
  assign pendKeep   = (pend & ~pendClrSw) | pendSet;
  assign pendMasked = pend & mask;
  assign reqOh      = NUM_IRQ'(1) << reqId;
  assign pendNext   = (pend & ~(pendClrSw | (ackTaken ? reqOh : '0))) | pendSet;

  // Lowest pending-and-enabled index wins.
  always_comb begin
    winId = '0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (pendMasked[i]) winId = ID_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    reqIdNext = reqId;
    isrIdNext = isrId;
    ackTaken  = 1'b0;
    rdataNext = rdataQ;

    unique case (state)
      IDLE: begin
        if (bus.global_en && (|pendMasked)) begin
          stateNext = REQ;
          reqIdNext = winId;
        end
      end
      REQ: begin
        // Mask changes do not cancel; only losing the pend bit or global_en does.
        if (bus.irq_ack) begin
          stateNext = SERVICE;
          isrIdNext = reqId;
          ackTaken  = 1'b1;
        end else if (!bus.global_en || !(|(pendKeep & reqOh))) begin
          stateNext = IDLE;
        end
      end
      SERVICE: begin
        if (wrStat) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase

    irqReqNext = (stateNext == REQ);
    vectorNext = VECTOR_BASE + 16'(reqIdNext) * 16'(VECTOR_STRIDE);

    if (bus.io_ren) begin
      if (bus.io_addr == ADDR_PEND)      rdataNext = 8'(pend);
      else if (bus.io_addr == ADDR_MASK) rdataNext = 8'(mask);
      else if (bus.io_addr == ADDR_STAT) rdataNext = {state, 3'b000, isrId};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irqSample <= '0;
      irqPrev   <= '0;
      pend      <= '0;
      mask      <= '0;
      reqId     <= '0;
      isrId     <= '0;
      irqReqQ   <= 1'b0;
      vectorQ   <= VECTOR_BASE;
      rdataQ    <= '0;
    end else begin
      irqSample <= irqIn;
      irqPrev   <= irqSample;
      pend      <= pendNext;
      if (wrMask) mask <= NUM_IRQ'(bus.io_wdata);
      reqId     <= reqIdNext;
      isrId     <= isrIdNext;
      irqReqQ   <= irqReqNext;
      vectorQ   <= vectorNext;
      rdataQ    <= rdataNext;
    end
  end

  assign bus.irq_req  = irqReqQ;
  assign bus.vector   = vectorQ;
  assign bus.io_rdata = rdataQ;
endmodule

// File: tb/tb_interrupt_ctrl.sv
// Bench for interrupt_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_interrupt_ctrl;
  localparam int unsigned NUM_IRQ = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  interrupt_ctrl_if #(.NUM_IRQ(NUM_IRQ)) bus ();

  interrupt_ctrl #(
    .NUM_IRQ(NUM_IRQ),
    .VECTOR_BASE(16'h0004),
    .VECTOR_STRIDE(4),
    .IO_BASE(8'hF0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int nChecks = 0;
  int nPass   = 0;
  int nFail   = 0;

  // Model state: phase 0 = waiting, 1 = requesting, 2 = in service.
  logic [3:0]  mSamp, mPrev, mPend, mMask;
  int          mPhase, mReqId, mIsrId;
  logic        mIrqReq;
  logic [15:0] mVec;
  logic [7:0]  mRdata;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nChecks++;
    assert (obs === exp) nPass = nPass + 1;
    else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelStep();
    logic [3:0] rises, clr, keep, cand;
    int off;
    if (rst) begin
      mSamp = '0; mPrev = '0; mPend = '0; mMask = '0;
      mPhase = 0; mReqId = 0; mIsrId = 0;
      mIrqReq = 1'b0; mVec = 16'h0004; mRdata = '0;
      return;
    end
    rises = mSamp & ~mPrev;
    off   = int'(bus.io_addr) - 240;
    if (bus.io_ren && off >= 0 && off <= 2)
      mRdata = (off == 0) ? {4'b0, mPend} :
               (off == 1) ? {4'b0, mMask} : {2'(mPhase), 3'b000, 3'(mIsrId)};
    clr  = (bus.io_wen && off == 0) ? bus.io_wdata[3:0] : 4'b0;
    keep = mPend & ~clr;
    case (mPhase)
      0: begin
        cand = mPend & mMask;
        if (bus.global_en && cand != 0) begin
          for (int i = 3; i >= 0; i--) if (cand[i]) mReqId = i;
          mPhase = 1;
        end
      end
      1: begin
        cand = keep | rises;
        if (bus.irq_ack) begin
          keep[mReqId] = 1'b0;
          mIsrId = mReqId;
          mPhase = 2;
        end else if (!bus.global_en || !cand[mReqId]) begin
          mPhase = 0;
        end
      end
      default: if (bus.io_wen && off == 2) mPhase = 0;
    endcase
    mPend = keep | rises;
    if (bus.io_wen && off == 1) mMask = bus.io_wdata[3:0];
    mPrev   = mSamp;
    mSamp   = bus.irq_in;
    mIrqReq = (mPhase == 1);
    mVec    = 16'h0004 + 16'(mReqId * 4);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    modelStep();
    check("irq_req", 16'(bus.irq_req), 16'(mIrqReq));
    check("vector", bus.vector, mVec);
    check("io_rdata", 16'(bus.io_rdata), 16'(mRdata));
  endtask

  task automatic ioWrite(input logic [7:0] a, input logic [7:0] d);
    bus.io_addr = a; bus.io_wdata = d; bus.io_wen = 1'b1;
    cycle();
    bus.io_wen = 1'b0;
  endtask

  task automatic ioRead(input logic [7:0] a);
    bus.io_addr = a; bus.io_ren = 1'b1;
    cycle();
    bus.io_ren = 1'b0;
  endtask

  task automatic pulseIrq(input logic [3:0] lines);
    bus.irq_in = lines;
    cycle();
    bus.irq_in = 4'b0;
  endtask

  task automatic ack();
    bus.irq_ack = 1'b1;
    cycle();
    bus.irq_ack = 1'b0;
  endtask

  task automatic waitReq(input string tag, input int budget);
    int n = 0;
    while (bus.irq_req !== 1'b1 && n < budget) begin
      cycle();
      n++;
    end
    check(tag, 16'(bus.irq_req), 16'h1);
  endtask

  initial begin
    rst = 1'b1;
    bus.irq_in = '0; bus.global_en = 1'b0; bus.irq_ack = 1'b0;
    bus.io_addr = '0; bus.io_wdata = '0; bus.io_wen = 1'b0; bus.io_ren = 1'b0;
    cycle(); cycle();
    rst = 1'b0;
    check("rst_irq_req", 16'(bus.irq_req), 16'h0);
    check("rst_vector", bus.vector, 16'h0004);
    check("rst_rdata", 16'(bus.io_rdata), 16'h0);

    // Two-cycle edge-to-request latency on line 1.
    ioWrite(8'hF1, 8'h03);
    bus.global_en = 1'b1;
    pulseIrq(4'b0010);
    check("t1_lat0", 16'(bus.irq_req), 16'h0);
    cycle();
    check("t1_lat1", 16'(bus.irq_req), 16'h0);
    cycle();
    check("t1_req", 16'(bus.irq_req), 16'h1);
    check("t1_vec", bus.vector, 16'h0008);
    ack();
    check("t1_ack_drop", 16'(bus.irq_req), 16'h0);
    ioRead(8'hF2);
    check("t1_stat", 16'(bus.io_rdata), 16'h0081);
    ioWrite(8'hF2, 8'h00);

    // Simultaneous lines 0 and 2: priority then the second request.
    ioWrite(8'hF1, 8'h05);
    pulseIrq(4'b0101);
    waitReq("t2_req0", 4);
    check("t2_vec0", bus.vector, 16'h0004);
    ack();
    ioWrite(8'hF2, 8'h00);
    waitReq("t2_req2", 4);
    check("t2_vec2", bus.vector, 16'h000C);

    // global_en drop cancels without touching PEND.
    bus.global_en = 1'b0;
    cycle();
    check("t3_drop", 16'(bus.irq_req), 16'h0);
    ioRead(8'hF0);
    check("t3_pend", 16'(bus.io_rdata), 16'h0004);
    bus.global_en = 1'b1;
    waitReq("t3_rereq", 4);
    check("t3_vec", bus.vector, 16'h000C);
    ack();
    ioWrite(8'hF2, 8'h00);

    // No nesting: an edge during service waits for EOI.
    ioWrite(8'hF1, 8'h0A);
    pulseIrq(4'b0010);
    waitReq("t4_req1", 4);
    ack();
    ioRead(8'hF2);
    check("t4_stat", 16'(bus.io_rdata), 16'h0081);
    ioWrite(8'hF1, 8'h08);
    pulseIrq(4'b1000);
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("t4_no_nest", 16'(bus.irq_req), 16'h0);
    end
    ioRead(8'hF0);
    check("t4_pend3", 16'(bus.io_rdata), 16'h0008);
    ioWrite(8'hF2, 8'h00);
    waitReq("t4_req3", 4);
    check("t4_vec3", bus.vector, 16'h0010);
    ack();
    ioWrite(8'hF2, 8'h00);

    // Set beats a same-cycle W1C; plain W1C clears; upper bits read 0; out-of-range read holds.
    ioWrite(8'hF1, 8'h00);
    pulseIrq(4'b0010);
    cycle();
    pulseIrq(4'b0010);
    ioWrite(8'hF0, 8'h02);
    ioRead(8'hF0);
    check("t5_set_wins", 16'(bus.io_rdata), 16'h0002);
    ioWrite(8'hF0, 8'h02);
    ioRead(8'hF0);
    check("t5_w1c", 16'(bus.io_rdata), 16'h0000);
    ioWrite(8'hF1, 8'hFF);
    ioRead(8'hF1);
    check("t5_mask_width", 16'(bus.io_rdata), 16'h000F);
    ioRead(8'hF3);
    check("t5_hold", 16'(bus.io_rdata), 16'h000F);
    ioWrite(8'hF1, 8'h00);

    // Reset while in service.
    ioWrite(8'hF1, 8'h01);
    pulseIrq(4'b0101);
    waitReq("t6_req", 4);
    ack();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("t6_irq_req", 16'(bus.irq_req), 16'h0);
    check("t6_vector", bus.vector, 16'h0004);
    for (int a = 0; a < 3; a++) begin
      ioRead(8'hF0 + 8'(a));
      check("t6_reg_zero", 16'(bus.io_rdata), 16'h0);
    end

    // Random traffic against the model.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 2) == 0) bus.irq_in = 4'($urandom);
      bus.global_en = ($urandom_range(0, 7) != 0);
      bus.irq_ack   = ($urandom_range(0, 3) == 0);
      bus.io_wen    = ($urandom_range(0, 4) == 0);
      bus.io_ren    = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 4))
        0:       bus.io_addr = 8'hF0;
        1:       bus.io_addr = 8'hF1;
        2:       bus.io_addr = 8'hF2;
        3:       bus.io_addr = 8'hF3;
        default: bus.io_addr = 8'($urandom);
      endcase
      bus.io_wdata = 8'($urandom);
      rst = ($urandom_range(0, 149) == 0);
      cycle();
    end
    rst = 1'b0; bus.io_wen = 1'b0; bus.io_ren = 1'b0; bus.irq_ack = 1'b0;
    cycle();

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
